// File: rtl/uart_rx_12b.sv
// 8N1 UART receiver that reassembles byte pairs {0000,hi[3:0]},{lo[7:0]} into 12-bit words.
// Includes a 2-flop input synchroniser, false-start rejection, break handling and an inter-byte timeout.
module uart_rx_12b #(
  parameter int CLOCK_FREQ   = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rxd,
  output logic [11:0] data,
  output logic        valid,
  output logic        frame_error,
  output logic        sync_error,
  output logic        busy
);

  localparam int          BAUD_DIV      = CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] BAUD_MAX      = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_MAX      = 16'(BAUD_DIV / 2);
  localparam int          TO_CYCLES     = TIMEOUT_BITS * (BAUD_DIV + 1);
  localparam int          TO_W          = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state, state_next;
  logic        rxd_meta, rxd_s, rxd_prev;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        byte_done;
  logic        hi_pending;
  logic [3:0]  hi_nibble;
  logic [TO_W-1:0] to_cnt;

  logic start_edge, half_hit, period_hit;
  logic cnt_clr, bit_take, stop_good, stop_bad;

  assign start_edge = rxd_prev & ~rxd_s;
  assign half_hit   = (baud_cnt == HALF_MAX);
  assign period_hit = (baud_cnt == BAUD_MAX);

  // Synchroniser flops reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_edge) state_next = START;
      START: if (half_hit) state_next = rxd_s ? IDLE : DATA;
      DATA:  if (period_hit && bit_cnt == 3'd7) state_next = STOP;
      STOP:  if (period_hit) state_next = rxd_s ? IDLE : BRK;
      BRK:   if (rxd_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    cnt_clr   = (state == IDLE) || (state == BRK) ||
                ((state == START) && half_hit) ||
                ((state == DATA) && period_hit);
    bit_take  = (state == DATA) && period_hit;
    stop_good = (state == STOP) && period_hit && rxd_s;
    stop_bad  = (state == STOP) && period_hit && !rxd_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      byte_done   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      baud_cnt    <= cnt_clr ? 16'd0 : baud_cnt + 16'd1;
      byte_done   <= stop_good;
      frame_error <= stop_bad;
      if (state != DATA)  bit_cnt <= 3'd0;
      else if (bit_take)  bit_cnt <= bit_cnt + 3'd1;
      if (bit_take)       shift_reg <= {rxd_s, shift_reg[7:1]};
    end
  end

  // shift_reg is untouched for a full start bit after a stop, so the pairing stage can read it a cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data       <= '0;
      valid      <= 1'b0;
      sync_error <= 1'b0;
      hi_pending <= 1'b0;
      hi_nibble  <= '0;
      to_cnt     <= '0;
    end else begin
      valid      <= 1'b0;
      sync_error <= 1'b0;
      if (stop_bad) begin
        hi_pending <= 1'b0;
      end else if (byte_done) begin
        if (hi_pending) begin
          data       <= {hi_nibble, shift_reg};
          valid      <= 1'b1;
          hi_pending <= 1'b0;
        end else if (shift_reg[7:4] == 4'd0) begin
          hi_nibble  <= shift_reg[3:0];
          hi_pending <= 1'b1;
          to_cnt     <= '0;
        end else begin
          sync_error <= 1'b1;
        end
      end else if (hi_pending && !busy) begin
        if (to_cnt == TO_LAST) begin
          sync_error <= 1'b1;
          hi_pending <= 1'b0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_12b.sv
// Directed and randomized checks of uart_rx_12b against a byte-level pairing model.
// Runs the receiver at 51 clocks per bit to keep simulation short.
module tb_uart_rx_12b;

  localparam int CF   = 5_000_000;
  localparam int BR   = 100_000;
  localparam int TOB  = 20;
  localparam int BIT  = CF / BR + 1;
  localparam int HALF = (CF / BR) / 2;
  localparam int TO   = TOB * BIT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rxd = 1'b1;
  logic [11:0] data;
  logic        valid, frame_error, sync_error, busy;

  uart_rx_12b #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd), .data(data), .valid(valid),
    .frame_error(frame_error), .sync_error(sync_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor state (written only by the monitor)
  logic [11:0] got_q[$];
  int          got_fe = 0, got_se = 0;
  int          wide_cnt = 0, overlap_cnt = 0, unstable_cnt = 0;
  int          cyc = 0, se_cyc = 0, fall_cyc = 0;
  logic [11:0] data_prev = 12'h000;
  logic        valid_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (valid) got_q.push_back(data);
    if (valid && valid_prev) wide_cnt++;
    if (frame_error && valid) overlap_cnt++;
    if (frame_error) got_fe++;
    if (sync_error) begin got_se++; se_cyc = cyc; end
    if (busy_prev && !busy) fall_cyc = cyc;
    if (reset_n && (data !== data_prev) && !valid) unstable_cnt++;
    data_prev  = data;
    valid_prev = valid;
    busy_prev  = busy;
  end

  // Reference model: byte-level pairing rules
  logic [11:0] exp_q[$];
  int          exp_fe = 0, exp_se = 0;
  bit          m_hi = 1'b0;
  logic [3:0]  m_nib = 4'h0;
  int          chk_idx = 0;

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      exp_fe++;
      m_hi = 1'b0;
    end else if (m_hi) begin
      exp_q.push_back({m_nib, b});
      m_hi = 1'b0;
    end else if (b[7:4] == 4'h0) begin
      m_nib = b[3:0];
      m_hi  = 1'b1;
    end else begin
      exp_se++;
    end
  endtask

  task automatic model_timeout();
    if (m_hi) begin
      exp_se++;
      m_hi = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int bc);
    model_byte(b, stop_ok);
    uart_rxd = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (bc) @(negedge clk);
    end
    uart_rxd = stop_ok;
    repeat (bc) @(negedge clk);
    uart_rxd = 1'b1;
    $display("[TB] sent byte %02h stop=%0d bit=%0d", b, stop_ok, bc);
  endtask

  task automatic idle_bits(input int n);
    uart_rxd = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic checkpoint(input string name);
    idle_bits(3);
    check({name, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_word"}, {20'h0, got_q[i]}, {20'h0, exp_q[i]});
      $display("[TB] %s word %0d data=%03h", name, i, got_q[i]);
    end
    check({name, "_frame_err"}, 32'(got_fe), 32'(exp_fe));
    check({name, "_sync_err"}, 32'(got_se), 32'(exp_se));
    check({name, "_valid_width"}, 32'(wide_cnt), 32'd0);
    check({name, "_data_stable"}, 32'(unstable_cnt), 32'd0);
    check({name, "_fe_valid_overlap"}, 32'(overlap_cnt), 32'd0);
    chk_idx = exp_q.size();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, rise_k, fall_k, d, bc, gap;
    logic [11:0] w;
    logic [7:0]  junk;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", {20'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_errors", {30'h0, frame_error, sync_error}, 32'h0);
    reset_n = 1'b1;
    idle_bits(2);

    // Single word, zero gap between frames
    send_byte(8'h0A, 1'b1, BIT);
    send_byte(8'h5C, 1'b1, BIT);
    checkpoint("word_a5c");

    // Extremes back-to-back
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'h0F, 1'b1, BIT);
    send_byte(8'hFF, 1'b1, BIT);
    checkpoint("extremes");

    // Bad high byte, then resync
    send_byte(8'h3C, 1'b1, BIT);
    send_byte(8'h01, 1'b1, BIT);
    send_byte(8'h23, 1'b1, BIT);
    checkpoint("resync");

    // Framing error with line held low (break)
    send_byte(8'h05, 1'b0, BIT);
    uart_rxd = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("break_busy_high", {31'h0, busy}, 32'h1);
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("break_busy_low", {31'h0, busy}, 32'h0);
    send_byte(8'h07, 1'b1, BIT);
    send_byte(8'h89, 1'b1, BIT);
    checkpoint("frame_err");

    // Glitch shorter than half a bit: false start
    uart_rxd = 1'b0;
    rise_k = -1;
    fall_k = -1;
    for (k = 0; k < 200 && fall_k < 0; k++) begin
      @(negedge clk);
      if (k == 10) uart_rxd = 1'b1;
      if (busy && rise_k < 0) rise_k = k;
      if (!busy && rise_k >= 0 && fall_k < 0) fall_k = k;
    end
    uart_rxd = 1'b1;
    check("glitch_busy_seen", {31'h0, (rise_k >= 0 && fall_k >= 0)}, 32'h1);
    check("glitch_busy_len", {31'h0, ((fall_k - rise_k) <= HALF + 2)}, 32'h1);
    checkpoint("glitch");

    // Inter-byte timeout
    send_byte(8'h04, 1'b1, BIT);
    idle_bits(25);
    model_timeout();
    d = se_cyc - fall_cyc;
    $display("[TB] timeout delay %0d cycles after stop sample", d);
    check("timeout_window", {31'h0, (d >= TO - 2 && d <= TO + 4)}, 32'h1);
    checkpoint("timeout");

    // Reset in the middle of the low byte
    send_byte(8'h0A, 1'b1, BIT);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = 1'(i & 1);
      repeat (BIT) @(negedge clk);
    end
    check("midframe_busy", {31'h0, busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_data", {20'h0, data}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_pulses", {29'h0, valid, frame_error, sync_error}, 32'h0);
    m_hi = 1'b0;
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    idle_bits(2);
    send_byte(8'h0F, 1'b1, BIT);
    send_byte(8'hEE, 1'b1, BIT);
    checkpoint("after_reset");

    // Randomized words, optional junk bytes, +-1 cycle/bit baud skew, short gaps
    for (int n = 0; n < 6; n++) begin
      w   = 12'($urandom);
      bc  = BIT - 1 + int'($urandom_range(2));
      gap = int'($urandom_range(3));
      if ($urandom_range(3) == 0) begin
        junk = 8'($urandom_range(16, 255));
        send_byte(junk, 1'b1, bc);
      end
      send_byte({4'h0, w[11:8]}, 1'b1, bc);
      idle_bits(gap);
      send_byte(w[7:0], 1'b1, bc);
    end
    checkpoint("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
